// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcodes, flag bit positions and FSM states.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NOT,
        OP_SHL,
        OP_SHR,
        OP_SAR,
        OP_ROL,
        OP_ROR,
        OP_SLT,
        OP_SLTU,
        OP_MUL,
        OP_RSV14,
        OP_RSV15
    } op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

endpackage

// File: rtl/alu_pipe_comb.sv
// Combinational datapath for every single-cycle opcode.
// MUL and the reserved opcodes produce zero result and zero flags here.
module alu_pipe_comb
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [SHW-1:0]        sh;
    logic                  sh_nz;
    logic [WIDTH:0]        add_ext;
    logic [WIDTH-1:0]      sub_res;
    logic [WIDTH:0]        shl_ext;
    logic [WIDTH:0]        shr_ext;
    logic signed [WIDTH:0] sar_ext;
    logic [2*WIDTH-1:0]    rol_ext;
    logic [2*WIDTH-1:0]    ror_ext;
    logic                  c;
    logic                  v;
    logic                  no_flags;

    // Extra bit on the shifted-out side captures the last bit shifted out
    assign sh      = b[SHW-1:0];
    assign sh_nz   = |sh;
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_res = a - b;
    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;
    assign sar_ext = $signed({a, 1'b0}) >>> sh;
    assign rol_ext = {a, a} << sh;
    assign ror_ext = {a, a} >> sh;

    always_comb begin
        result   = '0;
        c        = 1'b0;
        v        = 1'b0;
        no_flags = 1'b0;
        unique case (op_e'(opcode))
            OP_ADD: begin
                result = add_ext[WIDTH-1:0];
                c      = add_ext[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = sub_res;
                c      = a < b;
                v      = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = shl_ext[WIDTH-1:0];
                c      = shl_ext[WIDTH];
            end
            OP_SHR: begin
                result = shr_ext[WIDTH:1];
                c      = shr_ext[0];
            end
            OP_SAR: begin
                result = sar_ext[WIDTH:1];
                c      = sar_ext[0];
            end
            OP_ROL: begin
                result = rol_ext[2*WIDTH-1:WIDTH];
                c      = sh_nz && result[0];
            end
            OP_ROR: begin
                result = ror_ext[WIDTH-1:0];
                c      = sh_nz && result[WIDTH-1];
            end
            OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: result = WIDTH'(a < b);
            OP_MUL, OP_RSV14, OP_RSV15: no_flags = 1'b1;
        endcase
    end

    always_comb begin
        flags = '0;
        if (!no_flags) begin
            flags[FLAG_Z] = (result == '0);
            flags[FLAG_N] = result[WIDTH-1];
            flags[FLAG_C] = c;
            flags[FLAG_V] = v;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and a shift-add multiplier FSM.
// Single-cycle ops land in the output register at the accepting edge.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
    localparam logic [SHW:0] CNT_DONE = (SHW+1)'(WIDTH);

    state_e             state_q, state_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_flags;
    logic               out_free;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [3:0]         mul_flags;

    alu_pipe_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_IDLE) && out_free;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // The final step and the writeback share an edge to hit WIDTH-cycle latency
    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign prod     = (cnt_q == CNT_DONE) ? acc_q : acc_step;

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (prod[WIDTH-1:0] == '0);
        mul_flags[FLAG_N] = prod[WIDTH-1];
        mul_flags[FLAG_C] = |prod[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_V] = |prod[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (op_e'(opcode) == OP_MUL) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_result;
                        flags_d     = alu_flags;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q != CNT_DONE) begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
                if (cnt_q >= CNT_LAST && out_free) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = prod[WIDTH-1:0];
                    flags_d     = mul_flags;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=16 with directed vectors.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  opcode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic [3:0]  flags;

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  f;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: one transfer per cycle where out_valid && out_ready
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got=%0h want=none", result);
            end else begin
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.r));
                check("flags", 32'(flags), 32'(e.f));
            end
        end
    end

    task automatic issue(input op_e op, input logic [15:0] ia,
                         input logic [15:0] ib, input logic push,
                         input logic [15:0] er, input logic [3:0] ef);
        bit done = 0;
        in_valid = 1'b1;
        opcode   = op;
        a        = ia;
        b        = ib;
        for (int i = 0; i < 50 && !done; i++) begin
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        opcode   = 4'($urandom);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got=no_accept want=accept");
        end else if (push) begin
            sb.push_back({er, ef});
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;

        issue(OP_ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 4'b1010);
        check("add_latency", 32'(out_valid), 32'd1);
        issue(OP_SUB, 16'h8000, 16'h0001, 1, 16'h7FFF, 4'b0001);
        issue(OP_SLT, 16'h8000, 16'h0001, 1, 16'h0001, 4'b0000);
        issue(OP_SAR, 16'h8000, 16'h0004, 1, 16'hF800, 4'b0100);
        issue(OP_ROL, 16'h8001, 16'h0001, 1, 16'h0003, 4'b0010);
        issue(OP_SHL, 16'h1234, 16'h0000, 1, 16'h1234, 4'b0000);
        issue(OP_SHL, 16'h8001, 16'h0001, 1, 16'h0002, 4'b0010);
        issue(OP_SHR, 16'h0003, 16'h0001, 1, 16'h0001, 4'b0010);
        issue(OP_ROR, 16'h0001, 16'h0011, 1, 16'h8000, 4'b0110);
        issue(OP_SLTU, 16'h0001, 16'h8000, 1, 16'h0001, 4'b0000);
        issue(OP_XOR, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 4'b1000);
        issue(OP_NOT, 16'h0F0F, 16'h0000, 1, 16'hF0F0, 4'b0100);
        issue(OP_AND, 16'h0F0F, 16'h00FF, 1, 16'h000F, 4'b0000);
        issue(OP_OR, 16'h0000, 16'h0000, 1, 16'h0000, 4'b1000);
        issue(OP_RSV14, 16'h0000, 16'h0000, 1, 16'h0000, 4'b0000);
        issue(OP_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 4'b0101);
        issue(OP_SUB, 16'h0001, 16'h0002, 1, 16'hFFFF, 4'b0110);

        issue(OP_MUL, 16'h0100, 16'h0100, 1, 16'h0000, 4'b1011);
        for (int i = 1; i < 16; i++) begin
            check("mul_busy_ready", 32'(in_ready), 32'd0);
            check("mul_busy_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("mul_busy_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("mul_latency", 32'(out_valid), 32'd1);
        issue(OP_MUL, 16'h0003, 16'h0005, 1, 16'h000F, 4'b0000);
        repeat (20) @(posedge clk);
        #1;

        out_ready = 1'b0;
        issue(OP_ADD, 16'h0001, 16'h0002, 1, 16'h0003, 4'b0000);
        check("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        opcode   = OP_ADD;
        a        = 16'h0003;
        b        = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'(result), 32'h0003);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        sb.push_back({16'h0007, 4'b0000});
        in_valid = 1'b0;
        check("bp_next_result", 32'(result), 32'h0007);
        check("bp_next_valid", 32'(out_valid), 32'd1);

        issue(OP_MUL, 16'h0003, 16'h0005, 0, 16'h0000, 4'b0000);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_quiet", 32'(out_valid), 32'd0);
        issue(OP_ADD, 16'h0002, 16'h0003, 1, 16'h0005, 4'b0000);
        check("post_abort_valid", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 16-bit combinational ALU.
- Adds configurable width, an extended 16-entry opcode space, variable shifts and rotates, compares, status flags and an iterative multiply.
- Uses valid/ready handshakes on input and output, so it can sit between a register-file read stage and a writeback stage with backpressure.

Parameters:
- WIDTH, 16, operand and result width. Must be a power of 2 and at least 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B. Bits [SHW-1:0] give the shift amount for shift/rotate ops.
- opcode  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flags  out  4  {Z,N,C,V}, registered with result.

Behaviour:
- Reset (rst high at a clock edge): state IDLE, out_valid=0, result=0, flags=0, multiply counter=0. in_ready=1 in the cycle after reset. A reset during a multiply aborts it and produces no output.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Request accepted on an edge where in_valid && in_ready. a, b and opcode are captured at that edge; later changes are ignored.
  - Output transfers on an edge where out_valid && out_ready.
  - result and flags hold stable while out_valid && !out_ready.
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOT a.
  - 6 SHL by b[SHW-1:0]; 7 SHR logical; 8 SAR arithmetic; 9 ROL; 10 ROR.
  - 11 SLT signed (result 1 or 0); 12 SLTU unsigned.
  - 13 MUL (low WIDTH bits of unsigned product).
  - 14 and 15 reserved: result=0, flags=0.
- Single-cycle ops (all except 13): result and flags are written at the accepting edge, and out_valid is high from that edge onward. Latency is 1 cycle. Back-to-back acceptance is allowed when out_ready=1, giving full throughput.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (a<b unsigned); V = signed overflow.
  - Shifts/rotates: C = last bit shifted or rotated out, 0 when the amount is 0; V = 0.
  - MUL: C = V = (upper WIDTH bits of the 2*WIDTH product != 0).
  - All other ops: C = V = 0.
- MUL FSM, states IDLE and MUL:
  - IDLE to MUL on accepting opcode 13. Load multiplicand, multiplier and a 2*WIDTH accumulator; counter=0.
  - In MUL, each cycle performs one shift-add step and increments the counter.
  - After WIDTH steps, the block writes result/flags and returns to IDLE, provided the output register is free (!out_valid || out_ready). Otherwise it stays in MUL with the product held until the output register is free.
  - Nominal latency: out_valid rises at the edge WIDTH cycles after the accepting edge. in_ready=0 throughout MUL.
- Boundary cases:
  - Shift amount 0 returns a unchanged.
  - Rotate amounts are taken modulo WIDTH.
  - Simultaneous output drain and new acceptance in the same edge is legal; the new result replaces the old one.

Decomposition:
- Package alu_pipe_pkg holds:
  - the opcode enum (OP_ADD through OP_MUL, OP_RSV14, OP_RSV15);
  - flag bit index constants (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0);
  - the state enum (ST_IDLE, ST_MUL).
- One sub-module: alu_pipe_comb, the purely combinational datapath for single-cycle ops. Inputs are a, b and opcode; outputs are result and flags.
- The handshake, output register and MUL FSM live in the top module.

Test Plan (WIDTH=16):
- ADD a=0xFFFF, b=0x0001, out_ready=1 -> result=0x0000, flags Z=1 N=0 C=1 V=0; out_valid exactly 1 cycle after acceptance.
- SUB a=0x8000, b=0x0001 -> result=0x7FFF, V=1, C=0, N=0. Also SLT a=0x8000, b=0x0001 -> result=0x0001.
- SAR a=0x8000 by 4 -> result=0xF800, N=1, C=0. ROL a=0x8001 by 1 -> result=0x0003, C=1. SHL by 0 -> result=a, C=0.
- MUL a=0x0100, b=0x0100 -> result=0x0000, C=V=1, Z=1; in_ready=0 for 16 cycles; out_valid 16 cycles after acceptance. MUL 0x0003×0x0005 -> result=0x000F, C=V=0.
- Backpressure: out_ready=0, issue ADD 1+2 then ADD 3+4 -> result 0x0003 holds and in_ready=0. Raising out_ready drains 0x0003, and 0x0007 appears on the next edge.
- rst pulsed on the 5th cycle of a MUL -> out_valid=0, in_ready=1 next cycle, no MUL result ever emitted. A subsequent ADD completes normally.
